// File: rtl/ddr3_rd_pkg.sv
// Shared types and default sizing for the DDR3 read arbiter and its tag FIFO.
package ddr3_rd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic       req_id;
    logic [1:0] tag;
  } tag_entry_t;

  localparam int DEF_BURST_LEN       = 15;
  localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// Show-ahead FIFO of {req_id, tag} for issued bursts; occupancy is the
// outstanding-burst count.
module ddr3_tag_fifo
  import ddr3_rd_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [2:0]    din,
  input  logic          pop,
  output logic [2:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_read_arbiter.sv
// Two-requester round-robin DDR3 burst-read arbiter with credit limiting and
// tag-FIFO routing of returned beats back to the owning requester.
module ddr3_read_arbiter
  import ddr3_rd_pkg::*;
#(
  parameter int BURST_LEN       = DEF_BURST_LEN,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int DATA_W          = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [28:0]       req0_addr_data,
  input  logic              req0_addr_valid,
  output logic              req0_addr_ready,
  input  logic [28:0]       req1_addr_data,
  input  logic              req1_addr_valid,
  output logic              req1_addr_ready,
  output logic [26:0]       avm_address,
  output logic              avm_read,
  output logic [4:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_tag,
  output logic              rsp_last,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic              rsp_error
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  state_t        state;
  logic          last_grant;
  tag_entry_t    pend;
  logic          credit;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [28:0]   sel_data;
  logic          issue_done;
  logic [2:0]    fifo_dout;
  tag_entry_t    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop;
  logic [BW-1:0] beat;
  logic          beat_last;

  assign avm_burstcount = 5'(BURST_LEN);

  // last_grant==1 means requester 1 won last time, so requester 0 wins a tie.
  assign credit          = (fifo_count < CW'(MAX_OUTSTANDING));
  assign grant0          = req0_addr_valid & (~req1_addr_valid | last_grant);
  assign grant1          = req1_addr_valid & (~req0_addr_valid | ~last_grant);
  assign req0_addr_ready = (state == ST_IDLE) & grant0 & credit;
  assign req1_addr_ready = (state == ST_IDLE) & grant1 & credit;
  assign accept          = req0_addr_ready | req1_addr_ready;
  assign sel_data        = req1_addr_ready ? req1_addr_data : req0_addr_data;
  assign issue_done      = (state == ST_ISSUE) & ~avm_waitrequest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= '0;
      pend        <= '0;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            avm_address <= sel_data[26:0];
            pend.req_id <= req1_addr_ready;
            pend.tag    <= sel_data[28:27];
            last_grant  <= req1_addr_ready;
            avm_read    <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ddr3_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .CW   (CW)
  ) u_tag_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (issue_done & ~fifo_full),
    .din    (pend),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign head      = tag_entry_t'(fifo_dout);
  assign beat_last = (beat == LAST_BEAT);
  assign fifo_pop  = avm_readdatavalid & ~fifo_empty & beat_last;

  // Stray beats with nothing outstanding only raise the sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_last   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_error  <= 1'b0;
      beat       <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_last   <= 1'b0;
      if (avm_readdatavalid) begin
        if (fifo_empty) begin
          rsp_error <= 1'b1;
        end else begin
          rsp_data   <= avm_readdata;
          rsp_tag    <= head.tag;
          rsp_last   <= beat_last;
          rsp0_valid <= ~head.req_id;
          rsp1_valid <= head.req_id;
          beat       <= beat_last ? '0 : beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
// Self-checking bench for ddr3_read_arbiter: vector table of single bursts plus
// contention, credit, interleave, error and reset sequences; returns are scoreboarded.
module tb_ddr3_read_arbiter;
  import ddr3_rd_pkg::*;

  localparam int DATA_W = 256;
  localparam int BL     = 15;

  logic              clk;
  logic              reset_n;
  logic [28:0]       req0_addr_data, req1_addr_data;
  logic              req0_addr_valid, req1_addr_valid;
  logic              req0_addr_ready, req1_addr_ready;
  logic [26:0]       avm_address;
  logic              avm_read;
  logic [4:0]        avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_tag;
  logic              rsp_last;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp_error;

  ddr3_read_arbiter #(
    .BURST_LEN      (BL),
    .MAX_OUTSTANDING(4),
    .DATA_W         (DATA_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req0_addr_data   (req0_addr_data),
    .req0_addr_valid  (req0_addr_valid),
    .req0_addr_ready  (req0_addr_ready),
    .req1_addr_data   (req1_addr_data),
    .req1_addr_valid  (req1_addr_valid),
    .req1_addr_ready  (req1_addr_ready),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .rsp_data         (rsp_data),
    .rsp_tag          (rsp_tag),
    .rsp_last         (rsp_last),
    .rsp0_valid       (rsp0_valid),
    .rsp1_valid       (rsp1_valid),
    .rsp_error        (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        mask;
    logic [1:0]        tag;
    logic              last;
    logic [DATA_W-1:0] data;
  } rsp_exp_t;

  typedef struct {
    logic        id;
    logic [1:0]  tag;
    logic [26:0] addr;
    int          wait_cyc;
    int          base;
    int          exp_read_cycles;
    logic [1:0]  exp_mask;
  } vec_t;

  rsp_exp_t rsp_q[$];
  vec_t     vecs[4];
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_data(input int v);
    return {8{v[31:0]}};
  endfunction

  // Response monitor: every routed beat must match the scoreboard head.
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_route", {rsp1_valid, rsp0_valid}, e.mask);
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_last", rsp_last, e.last);
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs();
    check("rst_avm_read", avm_read, 1'b0);
    check("rst_avm_address", avm_address, 27'h0);
    check("rst_burstcount", avm_burstcount, 5'd15);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("rst_rsp_last", rsp_last, 1'b0);
    check("rst_rsp_tag", rsp_tag, 2'b00);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_error", rsp_error, 1'b0);
  endtask

  task automatic do_req(input logic id, input logic [1:0] tag, input logic [26:0] addr,
                        input int wait_cyc, input int read_cycles);
    bit found = 0;
    @(posedge clk); #1;
    if (id) begin req1_addr_valid = 1'b1; req1_addr_data = {tag, addr}; end
    else    begin req0_addr_valid = 1'b1; req0_addr_data = {tag, addr}; end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (id ? req1_addr_ready : req0_addr_ready) begin found = 1; break; end
    end
    check("grant_seen", found, 1'b1);
    check("grant_other", id ? req0_addr_ready : req1_addr_ready, 1'b0);
    @(posedge clk); #1;
    req0_addr_valid = 1'b0;
    req1_addr_valid = 1'b0;
    if (!found) return;
    avm_waitrequest = (wait_cyc > 0);
    for (int c = 0; c < read_cycles; c++) begin
      @(negedge clk);
      check("avm_read_hold", avm_read, 1'b1);
      check("avm_address", avm_address, addr);
      check("avm_burstcount", avm_burstcount, 5'd15);
      @(posedge clk); #1;
      avm_waitrequest = (c + 1 < wait_cyc);
    end
    @(negedge clk);
    check("avm_read_drop", avm_read, 1'b0);
  endtask

  task automatic send_burst(input logic [1:0] mask, input logic [1:0] tag, input int base,
                            input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      avm_readdatavalid = 1'b1;
      avm_readdata      = beat_data(base + b);
      rsp_q.push_back('{mask: mask, tag: tag, last: (b == BL - 1), data: beat_data(base + b)});
    end
  endtask

  task automatic rdv_off_and_drain();
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rsp_queue_empty", rsp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int g, last_n, accepts;
    bit seen;
    reset_n           = 1'b1;
    req0_addr_data    = '0;
    req1_addr_data    = '0;
    req0_addr_valid   = 1'b0;
    req1_addr_valid   = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    vecs[0] = '{id: 1'b0, tag: 2'd1, addr: 27'h0005A00, wait_cyc: 0, base: 'h100,
                exp_read_cycles: 1, exp_mask: 2'b01};
    vecs[1] = '{id: 1'b1, tag: 2'd2, addr: 27'h1234567, wait_cyc: 3, base: 'h200,
                exp_read_cycles: 4, exp_mask: 2'b10};
    vecs[2] = '{id: 1'b0, tag: 2'd3, addr: 27'h7FFFFFF, wait_cyc: 1, base: 'h300,
                exp_read_cycles: 2, exp_mask: 2'b01};
    vecs[3] = '{id: 1'b1, tag: 2'd0, addr: 27'h0000001, wait_cyc: 0, base: 'h400,
                exp_read_cycles: 1, exp_mask: 2'b10};

    foreach (vecs[i]) begin
      do_req(vecs[i].id, vecs[i].tag, vecs[i].addr, vecs[i].wait_cyc, vecs[i].exp_read_cycles);
      send_burst(vecs[i].exp_mask, vecs[i].tag, vecs[i].base, BL);
      rdv_off_and_drain();
      check("no_error_after_burst", rsp_error, 1'b0);
    end

    // Interleaved ownership: req1 burst then req0 burst, returns back-to-back.
    do_req(1'b1, 2'd1, 27'h0000AAA, 0, 1);
    do_req(1'b0, 2'd2, 27'h0000BBB, 0, 1);
    send_burst(2'b10, 2'd1, 'h500, BL);
    send_burst(2'b01, 2'd2, 'h600, BL);
    rdv_off_and_drain();

    // Contention after reset: grants alternate starting with req0.
    do_reset();
    @(posedge clk); #1;
    req0_addr_valid = 1'b1; req0_addr_data = {2'd2, 27'h0001000};
    req1_addr_valid = 1'b1; req1_addr_data = {2'd3, 27'h0002000};
    g = 0; last_n = -2;
    for (int n = 0; n < 40 && g < 4; n++) begin
      @(negedge clk);
      if (req0_addr_ready || req1_addr_ready) begin
        check("rr_grant", {req1_addr_ready, req0_addr_ready}, (g % 2 == 0) ? 2'b01 : 2'b10);
        check("grant_spacing", (n - last_n) >= 2, 1'b1);
        last_n = n;
        g++;
      end
    end
    @(posedge clk); #1;
    req0_addr_valid = 1'b0;
    req1_addr_valid = 1'b0;
    check("rr_grant_count", g, 4);
    repeat (2) @(negedge clk);
    send_burst(2'b01, 2'd2, 'h700, BL);
    send_burst(2'b10, 2'd3, 'h800, BL);
    send_burst(2'b01, 2'd2, 'h900, BL);
    send_burst(2'b10, 2'd3, 'hA00, BL);
    rdv_off_and_drain();

    // Credit limit: five back-to-back req0 requests, no returns.
    @(posedge clk); #1;
    accepts = 0;
    req0_addr_valid = 1'b1;
    req0_addr_data  = {2'd0, 27'h0000040};
    for (int n = 0; n < 60 && accepts < 4; n++) begin
      @(negedge clk);
      if (req0_addr_ready) begin
        accepts++;
        @(posedge clk); #1;
        req0_addr_data = {2'(accepts % 4), 27'(accepts * 'h100 + 'h40)};
      end
    end
    check("credit_issued", accepts, 4);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (req0_addr_ready) seen = 1;
    end
    check("credit_block", seen, 1'b0);
    seen = 0;
    for (int b = 0; b < BL; b++) begin
      send_burst(2'b01, 2'd0, 'hB00 + b, 1);
      rsp_q[rsp_q.size() - 1].last = (b == BL - 1);
      @(negedge clk);
      if (req0_addr_ready) seen = 1;
    end
    check("credit_block_during_return", seen, 1'b0);
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    check("credit_release", req0_addr_ready, 1'b1);
    @(posedge clk); #1;
    req0_addr_valid = 1'b0;
    @(negedge clk);
    check("fifth_read", avm_read, 1'b1);
    check("fifth_addr", avm_address, 27'h0000440);
    repeat (2) @(negedge clk);
    send_burst(2'b01, 2'd1, 'hC00, BL);
    send_burst(2'b01, 2'd2, 'hD00, BL);
    send_burst(2'b01, 2'd3, 'hE00, BL);
    send_burst(2'b01, 2'd0, 'hF00, BL);
    rdv_off_and_drain();

    // Stray return with nothing outstanding.
    check("error_clear_before", rsp_error, 1'b0);
    @(posedge clk); #1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = beat_data('hDEAD);
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    check("error_set", rsp_error, 1'b1);
    check("error_no_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    repeat (3) @(negedge clk);
    check("error_sticky", rsp_error, 1'b1);

    // Reset with two bursts outstanding, mid-return.
    do_reset();
    do_req(1'b0, 2'd1, 27'h0003333, 0, 1);
    do_req(1'b1, 2'd2, 27'h0004444, 0, 1);
    send_burst(2'b01, 2'd1, 'h1100, 3);
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    check("pre_reset_queue", rsp_q.size(), 0);
    do_reset();
    @(posedge clk); #1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = beat_data('h1200);
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    check("post_reset_error", rsp_error, 1'b1);
    check("post_reset_no_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    repeat (2) @(negedge clk);
    check("final_queue_empty", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_read_arbiter.md
DDR3_READ_ARBITER -- requirements
Module: ddr3_read_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 15, meaning DDR3 words per read burst (one 240-pixel row third).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of issued bursts not yet fully returned.
REQ-003 SHALL have parameter DATA_W, default 256, meaning the DDR3 read data width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-006 SHALL have ports req0_addr_data / req1_addr_data, input, 29, each {tag[1:0], word_addr[26:0]}.
REQ-007 SHALL have ports req0_addr_valid / req1_addr_valid, input, 1, request present.
REQ-008 SHALL have ports req0_addr_ready / req1_addr_ready, output, 1, request accepted this cycle.
REQ-009 SHALL have ports avm_address (output, 27), avm_read (output, 1), avm_burstcount (output, 5), avm_waitrequest (input, 1), forming the Avalon-MM read command.
REQ-010 SHALL have ports avm_readdata (input, DATA_W) and avm_readdatavalid (input, 1), forming the read return.
REQ-011 SHALL have ports rsp_data (output, DATA_W), rsp_tag (output, 2), rsp_last (output, 1), rsp0_valid / rsp1_valid (output, 1 each), forming the routed return with no backpressure.
REQ-012 SHALL have port rsp_error, output, 1, sticky flag for readdatavalid with no burst outstanding.

Function
REQ-013 SHALL implement states ST_IDLE and ST_ISSUE.
REQ-014 In ST_IDLE, a request is granted only when outstanding < MAX_OUTSTANDING; reqN_addr_ready is combinational: (state==ST_IDLE) & grantN & credit.
REQ-015 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; if one is valid, grant it.
REQ-016 On valid&ready, SHALL register word_addr into avm_address, store the tag and requester ID, and assert avm_read with avm_burstcount=BURST_LEN on the next cycle, with state ST_ISSUE.
REQ-017 In ST_ISSUE, address, burstcount and read SHALL hold stable while avm_waitrequest=1; when it is 0, SHALL push {req_id, tag} to the tag FIFO, deassert avm_read next cycle, and return to ST_IDLE.
REQ-018 At most one request SHALL be accepted per two cycles; no ready is asserted in ST_ISSUE.
REQ-019 Outstanding count SHALL equal tag FIFO occupancy; push and pop in the same cycle leave it unchanged.
REQ-020 A beat counter 0..BURST_LEN-1 SHALL advance on each avm_readdatavalid and wrap to 0 after BURST_LEN-1, popping the FIFO head at that beat.
REQ-021 Each beat SHALL appear on rsp_data one cycle after avm_readdatavalid, with rsp_tag = head tag, rsp_last=1 on the final beat, and only the head owner's rspN_valid high for one cycle.
REQ-022 avm_readdatavalid with an empty FIFO SHALL set rsp_error (cleared only by reset), drive no rspN_valid, and leave the counter unchanged.
REQ-023 A return may overlap issue of a later burst; command and return paths are independent.

Reset
REQ-024 On reset_n low (asynchronous), SHALL force: state ST_IDLE, avm_read 0, avm_address 0, avm_burstcount BURST_LEN, rsp0/1_valid 0, rsp_last 0, rsp_tag 0, rsp_data 0, rsp_error 0, beat counter 0, FIFO empty, last grant = requester 1 (so requester 0 wins first tie).
REQ-025 Reset mid-burst SHALL discard all outstanding tags; returns after reset release with an empty FIFO set rsp_error.

Structure
REQ-026 Package ddr3_rd_pkg SHALL hold the state enum, the {req_id, tag} struct, and default BURST_LEN/MAX_OUTSTANDING constants.
REQ-027 Tag FIFO SHALL be sub-module ddr3_tag_fifo (depth MAX_OUTSTANDING, width 3, show-ahead, full/empty/count).

Verification
REQ-028 Single request: req0 addr {2'b01, 27'h0005A00}, waitrequest 0 -> avm_read one cycle with addr 27'h0005A00 and burstcount 15; 15 returned beats -> 15 rsp0_valid pulses, rsp_tag 1, rsp_last on beat 15 only.
REQ-029 Contention: both valid continuously -> grants alternate 0,1,0,1 beginning with req0.
REQ-030 Credit limit: 5 back-to-back req0 requests with no returns -> 4 issued, ready held 0 until the first burst's 15th beat, then the 5th issues.
REQ-031 Waitrequest: held 1 for 3 cycles -> avm_address/avm_read stable for 4 cycles, single FIFO push.
REQ-032 Interleaved ownership: req1 burst then req0 burst, returns back-to-back -> first 15 beats on rsp1_valid, next 15 on rsp0_valid, no gap-induced misroute.
REQ-033 Error and reset: readdatavalid with no request -> rsp_error 1, no rsp valid; reset_n low with 2 outstanding -> all outputs to REQ-024 values immediately.
